// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the sequential ALU.
// Holds the 4-bit operation codes and the controller state encoding.
// Codes 0000-1010 match the original single-cycle ALU bit for bit.
// No ports (package).
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_SHL1 = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_NOP  = 4'b1000;
    localparam logic [3:0] OP_BNE  = 4'b1001;
    localparam logic [3:0] OP_BGTZ = 4'b1010;
    localparam logic [3:0] OP_DIV  = 4'b1011;
    localparam logic [3:0] OP_REM  = 4'b1100;
    localparam logic [3:0] OP_SLT  = 4'b1101;
    localparam logic [3:0] OP_SRL  = 4'b1110;
    localparam logic [3:0] OP_SLL  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        DONE
    } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle between the EX-stage control and the ALU.
// Request:  start, A, B, Selector_op   (driven by master)
// Response: busy, done, resultado, resultado_hi,
//           ZeroFlag, OverflowFlag, Div0Flag (driven by slave, the ALU)
interface alu_seq_if #(
    parameter int W = 32
);

    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [3:0]   Selector_op;
    logic         busy;
    logic         done;
    logic [W-1:0] resultado;
    logic [W-1:0] resultado_hi;
    logic         ZeroFlag;
    logic         OverflowFlag;
    logic         Div0Flag;

    modport master (
        output start, A, B, Selector_op,
        input  busy, done, resultado, resultado_hi,
        input  ZeroFlag, OverflowFlag, Div0Flag
    );

    modport slave (
        input  start, A, B, Selector_op,
        output busy, done, resultado, resultado_hi,
        output ZeroFlag, OverflowFlag, Div0Flag
    );

endinterface

// File: rtl/alu_iter_muldiv.sv
// alu_iter_muldiv: shared W-step iterative datapath for unsigned multiply
// (shift-add) and unsigned divide (restoring).
// Ports:
//   clk, reset   clock, async active-high reset
//   load         capture a (into lo) and b (multiplicand/divisor), clear hi
//   step         advance one iteration
//   is_div       1 = restoring-divide step, 0 = shift-add multiply step
//   a, b         operands, only sampled on load
//   hi, lo       register contents after the current step
//                (MUL: product high/low; DIV: remainder/quotient)
module alu_iter_muldiv
    import alu_seq_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         step,
    input  logic         is_div,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    logic [W-1:0] hi_q, hi_d;
    logic [W-1:0] lo_q, lo_d;
    logic [W-1:0] m_q, m_d;

    logic [W:0]   sum;
    logic [W:0]   shifted;
    logic [W:0]   trial;
    logic [W-1:0] hi_step;
    logic [W-1:0] lo_step;

    // One iteration. Multiply: add the multiplicand when the next multiplier
    // bit is set, then shift {carry,hi,lo} right. Divide: shift the next
    // dividend bit into the partial remainder and keep the difference only
    // when it did not borrow; trial[W] is the borrow since the shifted
    // remainder is always below twice the divisor.
    always_comb begin
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        shifted = {hi_q, lo_q[W-1]};
        trial   = shifted - {1'b0, m_q};
        hi_step = sum[W:1];
        lo_step = {sum[0], lo_q[W-1:1]};
        if (is_div) begin
            if (!trial[W]) begin
                hi_step = trial[W-1:0];
                lo_step = {lo_q[W-2:0], 1'b1};
            end else begin
                hi_step = shifted[W-1:0];
                lo_step = {lo_q[W-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        m_d  = m_q;
        if (load) begin
            hi_d = '0;
            lo_d = a;
            m_d  = b;
        end else if (step) begin
            hi_d = hi_step;
            lo_d = lo_step;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
            m_q  <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
            m_q  <= m_d;
        end
    end

    // The controller registers the final result on the same edge as the
    // last step, so it needs the post-step value rather than the flops.
    assign hi = hi_step;
    assign lo = lo_step;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: clocked EX-stage ALU with start/busy/done handshake.
// Single-cycle ops complete one cycle after start; MUL/DIV/REM iterate W cycles.
// Ports:
//   clk, reset   clock, async active-high reset
//   bus          alu_seq_if slave: start, A, B, Selector_op in;
//                busy, done, resultado, resultado_hi and flags out
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int W   = 32,
    parameter int SHW = $clog2(W)
) (
    input  logic     clk,
    input  logic     reset,
    alu_seq_if.slave bus
);

    localparam int CW = $clog2(W) + 1;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [3:0]    op_q, op_d;
    logic [W-1:0]  res_q, res_d;
    logic [W-1:0]  res_hi_q, res_hi_d;
    logic          zero_q, zero_d;
    logic          ovf_q, ovf_d;
    logic          div0_q, div0_d;

    logic [W-1:0]  a, b;
    logic [3:0]    op;
    logic [W-1:0]  sum, diff;
    logic [W-1:0]  sc_res;
    logic          sc_ovf;
    logic          sc_div0;
    logic          is_long;
    logic          load, step;
    logic [W-1:0]  it_hi, it_lo;

    assign a  = bus.A;
    assign b  = bus.B;
    assign op = bus.Selector_op;

    // Results for every op that finishes in one cycle, including the
    // divide-by-zero shortcut. MUL falls to the default; it always iterates.
    always_comb begin
        sum     = a + b;
        diff    = a - b;
        sc_res  = '0;
        sc_ovf  = 1'b0;
        sc_div0 = 1'b0;
        case (op)
            OP_ADD: begin
                sc_res = sum;
                sc_ovf = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
            end
            OP_SUB: begin
                sc_res = diff;
                sc_ovf = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
            end
            OP_SLTU: sc_res = {{(W-1){1'b0}}, (a < b)};
            OP_AND:  sc_res = a & b;
            OP_OR:   sc_res = a | b;
            OP_SHL1: sc_res = a << 1;
            OP_XOR:  sc_res = a ^ b;
            OP_NOP:  sc_res = '0;
            OP_BNE:  sc_res = {{(W-1){1'b0}}, (a == b)};
            OP_BGTZ: sc_res = {{(W-1){1'b0}}, (a == '0)};
            OP_DIV: begin
                sc_res  = '1;
                sc_div0 = 1'b1;
            end
            OP_REM: begin
                sc_res  = a;
                sc_div0 = 1'b1;
            end
            OP_SLT:  sc_res = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SRL:  sc_res = a >> b[SHW-1:0];
            OP_SLL:  sc_res = a << b[SHW-1:0];
            default: sc_res = '0;
        endcase
    end

    // Divide by zero never enters the iterative path.
    assign is_long = (op == OP_MUL) ||
                     (((op == OP_DIV) || (op == OP_REM)) && (b != '0));

    // Controller: start is only honoured in IDLE; the result registers are
    // written exactly once per operation, on the edge that enters DONE.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        op_d     = op_q;
        res_d    = res_q;
        res_hi_d = res_hi_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        div0_d   = div0_q;
        load     = 1'b0;
        step     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (is_long) begin
                        load    = 1'b1;
                        op_d    = op;
                        count_d = CW'(W);
                        state_d = ITER;
                    end else begin
                        res_d    = sc_res;
                        res_hi_d = '0;
                        zero_d   = (sc_res == '0);
                        ovf_d    = sc_ovf;
                        div0_d   = sc_div0;
                        state_d  = DONE;
                    end
                end
            end
            ITER: begin
                step    = 1'b1;
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    res_d    = (op_q == OP_REM) ? it_hi : it_lo;
                    res_hi_d = (op_q == OP_MUL) ? it_hi : '0;
                    zero_d   = (((op_q == OP_REM) ? it_hi : it_lo) == '0);
                    ovf_d    = 1'b0;
                    div0_d   = 1'b0;
                    state_d  = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            op_q     <= '0;
            res_q    <= '0;
            res_hi_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            op_q     <= op_d;
            res_q    <= res_d;
            res_hi_q <= res_hi_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            div0_q   <= div0_d;
        end
    end

    alu_iter_muldiv #(
        .W(W)
    ) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .step   (step),
        .is_div (op_q != OP_MUL),
        .a      (a),
        .b      (b),
        .hi     (it_hi),
        .lo     (it_lo)
    );

    assign bus.busy         = (state_q == ITER);
    assign bus.done         = (state_q == DONE);
    assign bus.resultado    = res_q;
    assign bus.resultado_hi = res_hi_q;
    assign bus.ZeroFlag     = zero_q;
    assign bus.OverflowFlag = ovf_q;
    assign bus.Div0Flag     = div0_q;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, clocked successor to the datapath's single-cycle ALU.
- Keeps the existing 4-bit op encoding 0000–1010 bit-compatible.
- Adds iterative multiply (full-width product), iterative divide/remainder, signed compare and barrel shifts.
- Sits in the EX stage behind a start/busy/done handshake, so the control unit can stall on multi-cycle ops.

Parameters:
- W, 32, operand/result width (≥4, power of 2)
- SHW, $clog2(W), shift-amount width taken from B[SHW-1:0]

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only while idle
- A  in  W  operand A (unsigned unless op says signed)
- B  in  W  operand B
- Selector_op  in  4  operation code
- busy  out  1  high while a multi-cycle op iterates
- done  out  1  one-cycle pulse; result/flags valid from this cycle until the next done
- resultado  out  W  result (low half for MUL)
- resultado_hi  out  W  upper half of MUL product; 0 for all other ops
- ZeroFlag  out  1  resultado == 0
- OverflowFlag  out  1  signed overflow for ADD/SUB; 0 otherwise
- Div0Flag  out  1  DIV/REM with B == 0

Behaviour:
- Reset (async, active-high): all outputs 0, state IDLE, iteration counter 0. Reset mid-iteration aborts the op with no done pulse.
- States: IDLE, ITER, DONE.
  - IDLE + start, single-cycle op: compute, register result and flags, go to DONE.
  - IDLE + start, MUL/DIV/REM with B != 0: latch A, B and op; counter = W; go to ITER.
  - ITER: one shift-add (MUL) or restoring-subtract (DIV/REM) step per cycle; counter decrements. When the counter reaches 1, register the result and go to DONE.
  - DONE: lasts one cycle, then IDLE. A start in this cycle is ignored; start is accepted only in IDLE.
- Latency, counted from the edge that samples start:
  - Single-cycle ops: done on edge +1.
  - MUL/DIV/REM: done on edge +W+1; busy high on edges +1..+W, low in the done cycle.
- start while busy or in DONE is ignored. Operand changes during ITER have no effect (operands latched).
- resultado, resultado_hi and flags hold between done pulses.
- Op codes:
  - 0000 ADD: A+B mod 2^W, OverflowFlag = signed overflow.
  - 0001 SUB: A−B mod 2^W, OverflowFlag = signed overflow.
  - 0010 MUL: unsigned, iterative, 2W-bit product split across resultado_hi:resultado.
  - 0011 SLTU: 1 if A<B unsigned.
  - 0100 AND, 0101 OR, 0111 XOR.
  - 0110 SHL1: A<<1.
  - 1000 NOP: 0.
  - 1001 BNE: 0 if A!=B else 1.
  - 1010 BGTZ: 0 if A>0 unsigned else 1.
  - 1011 DIV: unsigned quotient.
  - 1100 REM: unsigned remainder.
  - 1101 SLT: signed compare.
  - 1110 SRL: A>>B[SHW-1:0], logical.
  - 1111 SLL: A<<B[SHW-1:0].
- Divide by zero: single-cycle path (done on edge +1). DIV → all ones; REM → A; Div0Flag = 1.
- ZeroFlag is computed on the registered resultado only, never on resultado_hi.

Decomposition:
- Package alu_seq_pkg holds:
  - localparam op codes: OP_ADD … OP_SLL.
  - State enum: IDLE, ITER, DONE.
- Sub-module alu_iter_muldiv: shared W-step shift-add / restoring-divide datapath. Controls: load, step, is_div. Outputs: hi, lo.
- The FSM, single-cycle ops and flags stay in alu_seq.

Test Plan (W=32):
- ADD 0x7FFFFFFF+1 → resultado 0x80000000, OverflowFlag 1, ZeroFlag 0, done at +1; SUB 5−5 → 0, ZeroFlag 1.
- MUL 0xFFFFFFFF×0xFFFFFFFF → resultado_hi 0xFFFFFFFE, resultado 0x00000001, busy high 32 cycles, done at +33.
- DIV 100/7 → 14; REM 100/7 → 2, each done at +33; DIV 9/0 → 0xFFFFFFFF, Div0Flag 1, done at +1.
- SLT 0xFFFFFFFF vs 1 → 1; SLTU same operands → 0; SRL 0x80000000 by B=31 → 1; BGTZ A=0 → 1.
- start pulsed every cycle during MUL → only the first accepted, single done; reset asserted at iteration 10 → outputs 0 immediately, no done, next start accepted normally.
- Legacy-compatibility sweep over ops 0000–1010 with random A/B → results identical to the single-cycle ALU's semantics.
